bram_port_arbiter: RTL and testbench



---
 rtl/bram_port_arbiter_pkg.sv | 26 ++
 rtl/bram_port_arbiter_rr_grant.sv | 36 +++
 rtl/bram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter.
//   RD_LATENCY  : cycles from command acceptance to read data at the requester
//   clog2()     : index width helper for the requester count
//   BPA_*_SLICE : part-select helpers for the flattened per-requester buses
`ifndef BRAM_PORT_ARBITER_PKG_SV
`define BRAM_PORT_ARBITER_PKG_SV

// Requester i's field inside a flattened bus; expects ADDR_BIT / DWIDTH in scope.
`define BPA_ADDR_SLICE(i) ((i) * ADDR_BIT) +: ADDR_BIT
`define BPA_DATA_SLICE(i) ((i) * DWIDTH) +: DWIDTH

package bram_port_arbiter_pkg;

  // One cycle in the command register plus one cycle of registered BRAM read.
  localparam int RD_LATENCY = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`endif

// File: rtl/bram_port_arbiter_rr_grant.sv
// Combinational rotate-priority encoder.
//   req   : request vector, one bit per requester
//   ptr   : index searched first; search continues ptr+1, ... modulo NREQ
//   grant : one-hot winner, or zero when no request is present
//   idx   : binary index of the winner (0 when none)
//   found : some requester won
module bram_port_arbiter_rr_grant #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    logic [IDX_W-1:0] j;
    // NOTE: every output gets a default before the search so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters.
//   clk, rst            : single clock, synchronous active-high reset
//   req_valid/we/lock   : per-requester command valid, write enable, burst lock
//   req_addr/req_wdata  : flattened per-requester address and write data
//   req_ready           : one-hot grant; the command is accepted this cycle
//   rsp_valid/rsp_rdata : one-hot read response, RD_LATENCY cycles after accept
//   bram_en/we/addr/din : registered command onto the BRAM port
//   bram_dout           : BRAM registered read data (1-cycle latency)
//   busy                : a command is pending or still in the pipeline
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 32,
  parameter int ADDR_BIT = 32,
  parameter int IDX_W    = clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_BIT-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [ADDR_BIT-1:0]      bram_addr,
  output logic [DWIDTH-1:0]        bram_din,
  input  logic [DWIDTH-1:0]        bram_dout,
  output logic                     busy
);

  // Unpack the flattened request buses.
  logic [ADDR_BIT-1:0] addr_arr  [NREQ];
  logic [DWIDTH-1:0]   wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[`BPA_ADDR_SLICE(g)];
    assign wdata_arr[g] = req_wdata[`BPA_DATA_SLICE(g)];
  end

  // Arbitration state.
  logic [IDX_W-1:0] ptr;
  logic             lock_valid;
  logic [IDX_W-1:0] lock_owner;

  // Pipeline: stage 0 drives the BRAM port, stage RD_LATENCY-1 meets bram_dout.
  logic [RD_LATENCY-1:0] stage_valid;
  logic [RD_LATENCY-1:0] stage_rd;
  logic [IDX_W-1:0]      stage_idx [RD_LATENCY];

  logic [NREQ-1:0]  rr_grant_vec;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;

  bram_port_arbiter_rr_grant #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (rr_grant_vec),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // A lock only holds while its owner keeps valid high; once valid drops the
  // round-robin result takes over in the same cycle.
  logic             lock_hit;
  logic [NREQ-1:0]  grant_vec;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;

  assign lock_hit = lock_valid & req_valid[lock_owner];

  always_comb begin
    grant_vec = '0;
    grant_idx = rr_idx;
    accept    = 1'b0;
    if (!rst) begin
      if (lock_hit) begin
        grant_vec[lock_owner] = 1'b1;
        grant_idx             = lock_owner;
        accept                = 1'b1;
      end else if (rr_found) begin
        grant_vec = rr_grant_vec;
        accept    = 1'b1;
      end
    end
  end

  assign req_ready = grant_vec;

  logic [IDX_W-1:0] ptr_next;
  assign ptr_next = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      lock_valid  <= 1'b0;
      lock_owner  <= '0;
      stage_valid <= '0;
      stage_rd    <= '0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
    end else begin
      // Without an accept no requester is valid, so any lock is released.
      lock_valid  <= accept & req_lock[grant_idx];
      bram_we     <= accept & req_we[grant_idx];
      stage_valid <= {stage_valid[RD_LATENCY-2:0], accept};
      stage_rd    <= {stage_rd[RD_LATENCY-2:0], accept & ~req_we[grant_idx]};
      if (accept) begin
        ptr        <= ptr_next;
        lock_owner <= grant_idx;
        bram_addr  <= addr_arr[grant_idx];
        bram_din   <= wdata_arr[grant_idx];
      end
    end
  end

  // NOTE: stage_idx is only meaningful when its stage_valid bit is set, so it
  // carries no reset and stays a plain data register.
  always_ff @(posedge clk) begin
    stage_idx[0] <= grant_idx;
    for (int k = 1; k < RD_LATENCY; k++) stage_idx[k] <= stage_idx[k-1];
  end

  assign bram_en = stage_valid[0];

  always_comb begin
    rsp_valid = '0;
    if (stage_valid[RD_LATENCY-1] && stage_rd[RD_LATENCY-1])
      rsp_valid[stage_idx[RD_LATENCY-1]] = 1'b1;
  end

  // BRAM output is already registered; pass it straight through.
  assign rsp_rdata = bram_dout;

  assign busy = (|req_valid) | (|stage_valid);

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_we    = '0;
  logic [NREQ-1:0]   req_lock  = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              bram_en;
  logic              bram_we;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_din;
  logic [DW-1:0]     bram_dout;
  logic              busy;

  bram_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, 1-cycle latency, 256 words.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[5] = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr[7:0]] <= bram_din;
      bram_dout <= mem[bram_addr[7:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [3:0]   lock;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [3:0]   exp_ready;
  } vec_t;

  typedef struct {
    int         due;
    logic       we;
    logic [31:0] addr;
    logic [31:0] din;
  } cmd_t;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q [$];
  rsp_t rsp_q [$];
  logic [31:0] ref_mem [256];
  bit mon_en = 1'b0;

  function automatic logic [127:0] pack4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, we, lk, input logic [127:0] a, wd,
                              input logic [3:0] er);
    vec_t r;
    r.valid = v; r.we = we; r.lock = lk; r.addr = a; r.wdata = wd; r.exp_ready = er;
    return r;
  endfunction

  // Monitor: BRAM command one cycle after accept, read response two cycles after.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        cmd_t c;
        c = cmd_q.pop_front();
        check("bram_en", bram_en, 1);
        check("bram_we", bram_we, c.we);
        check("bram_addr", bram_addr, c.addr);
        check("bram_din", bram_din, c.din);
      end else begin
        check("bram_en_idle", bram_en, 0);
        check("bram_we_idle", bram_we, 0);
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_valid", rsp_valid, 64'(4'b0001 << r.idx));
        check("rsp_rdata", rsp_rdata, r.data);
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
      end
    end
  end

  // Apply one cycle of stimulus and queue the expected results of the expected grant.
  task automatic drive(input vec_t v);
    int gi;
    logic [31:0] a;
    logic [31:0] d;
    @(posedge clk); #1;
    req_valid = v.valid;
    req_we    = v.we;
    req_lock  = v.lock;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    check("req_ready", req_ready, v.exp_ready);
    if (v.exp_ready != 0) begin
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (v.exp_ready[i]) gi = i;
      a = v.addr[gi*32 +: 32];
      d = v.wdata[gi*32 +: 32];
      cmd_q.push_back('{due: cyc + 1, we: v.we[gi], addr: a, din: d});
      if (v.we[gi]) ref_mem[a[7:0]] = d;
      else rsp_q.push_back('{due: cyc + 2, idx: gi, data: ref_mem[a[7:0]]});
    end
  endtask

  task automatic idle(input int n, input bit check_busy);
    for (int i = 0; i < n; i++) begin
      drive(mk(4'b0, 4'b0, 4'b0, '0, '0, 4'b0));
      if (check_busy) check("busy_idle", busy, 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0;
    @(posedge clk); #1;
    cmd_q.delete();
    rsp_q.delete();
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_din", bram_din, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 | i;
    ref_mem[5] = 32'hDEAD_BEEF;

    // Fairness: everyone reads continuously, grants rotate from ptr=0.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, pack4(20, 21, 22, 23), '0,
                       4'(4'b0001 << (k % 4))));
    // Single valid requester is granted every cycle.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, pack4(0, 0, 30 + k, 0), '0, 4'b0100));
    // Lock burst: requester 1 writes 10..12 while 0 and 3 wait; then 3, then 0.
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, pack4(0, 10, 0, 0), pack4(0, 1, 0, 0), 4'b0010));
    tbl.push_back(mk(4'b1011, 4'b0010, 4'b0010, pack4(40, 11, 0, 41), pack4(0, 2, 0, 0), 4'b0010));
    tbl.push_back(mk(4'b1011, 4'b0010, 4'b0010, pack4(40, 12, 0, 41), pack4(0, 3, 0, 0), 4'b0010));
    tbl.push_back(mk(4'b1001, 4'b0000, 4'b0000, pack4(40, 0, 0, 41), '0, 4'b1000));
    tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, pack4(40, 0, 0, 0), '0, 4'b0001));
    // Read the burst back.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, pack4(0, 0, 0, 10 + k), '0, 4'b1000));

    do_reset();

    // Single read of the preloaded word.
    drive(mk(4'b0100, 4'b0000, 4'b0000, pack4(0, 0, 5, 0), '0, 4'b0100));
    check("busy_active", busy, 1);
    idle(3, 1'b0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    idle(3, 1'b0);
    check("mem10", mem[10], 1);
    check("mem11", mem[11], 2);
    check("mem12", mem[12], 3);

    // Read-after-write on consecutive accepts.
    drive(mk(4'b0001, 4'b0001, 4'b0000, pack4(7, 0, 0, 0), pack4(32'h55, 0, 0, 0), 4'b0001));
    drive(mk(4'b0001, 4'b0000, 4'b0000, pack4(7, 0, 0, 0), '0, 4'b0001));
    idle(3, 1'b0);

    // Reset while a read is in flight: its response must be dropped.
    drive(mk(4'b0100, 4'b0000, 4'b0000, pack4(0, 0, 5, 0), '0, 4'b0100));
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_q.delete();
    rsp_q.delete();
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_bram_en", bram_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    // ptr back at 0: lowest valid index (1) wins over 3.
    drive(mk(4'b1010, 4'b0000, 4'b0000, pack4(0, 50, 0, 51), '0, 4'b0010));
    drive(mk(4'b1000, 4'b0000, 4'b0000, pack4(0, 0, 0, 51), '0, 4'b1000));

    // Drain, then a quiet stretch.
    idle(3, 1'b0);
    idle(5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
